// File: rtl/uart8_receiver.sv
// 8N1 UART receiver: oversampled clock, 2-flop input synchronizer,
// mid-bit sampling, one-cycle done/err pulses on frame completion.
module uart8_receiver #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in,
  output logic [7:0] out,
  output logic       done,
  output logic       busy,
  output logic       err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_sync1, r_rx_s;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]      r_idx, w_idx_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic [7:0]      r_out, w_out_nxt;
  logic            r_done, w_done_nxt;
  logic            r_err, w_err_nxt;

  // Synchronizer resets to idle-high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= in;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_out   <= w_out_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_out_nxt   = r_out;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        if (en && !r_rx_s) w_state_nxt = START_BIT;
      end
      START_BIT: begin
        if (r_cnt == HALF) begin
          w_cnt_nxt   = '0;
          w_state_nxt = r_rx_s ? IDLE : DATA_BITS;
        end
      end
      DATA_BITS: begin
        if (r_cnt == LAST) begin
          w_cnt_nxt          = '0;
          w_shift_nxt[r_idx] = r_rx_s;
          if (r_idx == 3'd7) begin
            w_idx_nxt   = '0;
            w_state_nxt = STOP_BIT;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end
      STOP_BIT: begin
        // Leaving at the stop-bit midpoint lets a back-to-back start edge be caught.
        if (r_cnt == LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
          if (r_rx_s) begin
            w_out_nxt  = r_shift;
            w_done_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    if (!en && r_state != IDLE) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_out_nxt   = r_out;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
    end
  end

  assign out  = r_out;
  assign done = r_done;
  assign err  = r_err;
  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_uart8_receiver.sv
// Directed + randomized frames against a frame-level model of the receiver.
module tb_uart8_receiver;
  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       in = 1'b1;
  logic [7:0] out;
  logic       done, busy, err;

  uart8_receiver #(.OVERSAMPLE(OS)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in),
    .out(out), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int done_n = 0, err_n = 0, busy_n = 0, viol_n = 0;
  logic prev_done = 1'b0, prev_err = 1'b0;
  logic [7:0] out_at_done = 8'h00;

  // Pulse monitor: cycle counts of done/err/busy and illegal pulse shapes.
  always @(posedge clk) begin
    #1;
    if (done) begin done_n++; out_at_done = out; end
    if (err)  err_n++;
    if (busy) busy_n++;
    if ((done && err) || (done && prev_done) || (err && prev_err)) viol_n++;
    prev_done = done;
    prev_err  = err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    in = v;
    repeat (OS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    in = 1'b1;
  endtask

  task automatic idle(input int n);
    in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Frame-level reference: a received frame updates out only if its stop bit is high.
  logic [7:0] exp_out = 8'h00;
  int exp_done = 0, exp_err = 0;
  task automatic model_frame(input logic [7:0] b, input bit stop_ok);
    if (stop_ok) begin exp_out = b; exp_done++; end
    else exp_err++;
  endtask

  int d0, e0, b0;
  logic [7:0] rb;
  bit rgood;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out", out, 8'h00);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    en    = 1'b1;
    idle(4);

    // Nominal frame
    d0 = done_n; e0 = err_n;
    send_frame(8'hA5, 1'b1); model_frame(8'hA5, 1'b1);
    idle(2);
    chk("a5_out", out, exp_out);
    chk("a5_done_cycles", done_n - d0, 1);
    chk("a5_err", err_n - e0, 0);
    chk("a5_busy_after", busy, 0);
    chk("a5_out_at_done", out_at_done, 8'hA5);
    idle(OS);

    // Glitch shorter than half a bit
    d0 = done_n; e0 = err_n; b0 = busy_n;
    in = 1'b0; repeat (4) @(negedge clk); in = 1'b1;
    idle(20);
    chk("fs_busy_seen", (busy_n - b0) > 0, 1);
    chk("fs_busy_now", busy, 0);
    chk("fs_done", done_n - d0, 0);
    chk("fs_err", err_n - e0, 0);
    chk("fs_out", out, exp_out);

    // Framing error
    d0 = done_n; e0 = err_n;
    send_frame(8'h3C, 1'b0); model_frame(8'h3C, 1'b0);
    idle(3*OS);
    chk("fe_err", err_n - e0, 1);
    chk("fe_done", done_n - d0, 0);
    chk("fe_out", out, exp_out);

    // Back-to-back frames
    d0 = done_n;
    send_frame(8'h00, 1'b1); model_frame(8'h00, 1'b1);
    chk("b2b_out0", out, exp_out);
    send_frame(8'hFF, 1'b1); model_frame(8'hFF, 1'b1);
    idle(2);
    chk("b2b_out1", out, exp_out);
    chk("b2b_done", done_n - d0, 2);
    idle(OS);

    // Reset during data bit 4 of 0x81
    d0 = done_n; e0 = err_n;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i == 0);
    in = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("mr_busy_async", busy, 0);
    chk("mr_out_async", out, 8'h00);
    in = 1'b1;
    repeat (5) @(negedge clk);
    chk("mr_out_hold", out, 8'h00);
    rst_n = 1'b1;
    exp_out = 8'h00;
    idle(2*OS);
    chk("mr_no_done", done_n - d0, 0);
    chk("mr_no_err", err_n - e0, 0);
    chk("mr_idle_busy", busy, 0);
    d0 = done_n;
    send_frame(8'h42, 1'b1); model_frame(8'h42, 1'b1);
    idle(2);
    chk("mr_out42", out, exp_out);
    chk("mr_done42", done_n - d0, 1);
    idle(OS);

    // Receiver disabled
    en = 1'b0;
    idle(2);
    d0 = done_n; e0 = err_n; b0 = busy_n;
    send_frame(8'h55, 1'b1);
    idle(OS);
    chk("dis_busy", busy_n - b0, 0);
    chk("dis_done", done_n - d0, 0);
    chk("dis_err", err_n - e0, 0);
    chk("dis_out", out, exp_out);
    en = 1'b1;
    idle(4);

    // Enable dropped mid-frame
    d0 = done_n; e0 = err_n;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    en = 1'b0;
    @(negedge clk);
    chk("ab_busy", busy, 0);
    idle(8*OS);
    en = 1'b1;
    idle(4);
    chk("ab_done", done_n - d0, 0);
    chk("ab_err", err_n - e0, 0);
    chk("ab_out", out, exp_out);

    // Randomized frames
    for (int k = 0; k < 10; k++) begin
      rb    = 8'($urandom);
      rgood = ($urandom_range(0, 3) != 0);
      d0 = done_n; e0 = err_n;
      send_frame(rb, rgood); model_frame(rb, rgood);
      idle(2);
      chk("rnd_out", out, exp_out);
      chk("rnd_done", done_n - d0, rgood ? 1 : 0);
      chk("rnd_err", err_n - e0, rgood ? 0 : 1);
      idle(3*OS + $urandom_range(0, 10));
    end

    chk("tot_done", done_n, exp_done);
    chk("tot_err", err_n, exp_err);
    chk("pulse_shape", viol_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart8_receiver.md
UART8_RECEIVER -- requirements
Module: uart8_receiver

Parameters
REQ-001 The block SHALL have parameter OVERSAMPLE, default 16, giving clk cycles per UART bit period (legal range 8..64, even).

Interface
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, OVERSAMPLE x baud rate, all logic on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port en, input, 1 bit: receiver enable.
REQ-005 The block SHALL have port in, input, 1 bit: serial rx line, idle high, asynchronous to clk.
REQ-006 The block SHALL have port out, output, 8 bits: last correctly framed received byte.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse on a valid frame.
REQ-008 The block SHALL have port busy, output, 1 bit: frame reception in progress.
REQ-009 The block SHALL have port err, output, 1 bit: one-cycle pulse on a framing error (stop bit low).

Function
REQ-010 The block SHALL pass in through a 2-flop synchronizer (reset value 1); all decisions SHALL use the synchronized value rx_s.
REQ-011 The block SHALL implement the states IDLE, START_BIT, DATA_BITS and STOP_BIT, plus a tick counter (0..OVERSAMPLE-1) and a 3-bit bit index.
REQ-012 In IDLE with en=1 and rx_s=0, the block SHALL enter START_BIT with the tick counter cleared and SHALL raise busy on the same edge.
REQ-013 In START_BIT, at tick OVERSAMPLE/2-1 (bit midpoint), the block SHALL clear the counter and enter DATA_BITS if rx_s=0; if rx_s=1 (false start), it SHALL return to IDLE with busy low, no done and no err.
REQ-014 In DATA_BITS, every OVERSAMPLE ticks, the block SHALL sample rx_s into shift-register bit [bit index], LSB first; after bit index 7 it SHALL clear the index and enter STOP_BIT.
REQ-015 In STOP_BIT, at tick OVERSAMPLE-1, if rx_s=1 the block SHALL load out with the shift register and pulse done for exactly one cycle, on the same edge.
REQ-016 In STOP_BIT, at tick OVERSAMPLE-1, if rx_s=0 the block SHALL pulse err for one cycle and leave out unchanged.
REQ-017 On the stop-bit sample edge, the block SHALL drop busy and return to IDLE, so that a start edge arriving in the second half of the stop bit is accepted.
REQ-018 done and err SHALL never be asserted in the same cycle, and neither SHALL last more than one cycle.
REQ-019 If en falls while busy, the block SHALL abort to IDLE on the next edge with busy low, no done and no err, and out unchanged.
REQ-020 out SHALL hold its value between frames and change only per REQ-015.
REQ-021 Data bit n SHALL be sampled 2 + OVERSAMPLE/2 + (n+1)*OVERSAMPLE cycles (+/-1) after the falling edge of in.

Reset
REQ-022 While rst_n=0, the block SHALL hold out=8'h00, done=0, busy=0, err=0, state=IDLE, counters=0 and synchronizer=1, regardless of clk.
REQ-023 Assertion of rst_n mid-frame SHALL discard the partial byte with no done and no err; after release the block SHALL wait for a new falling edge.
REQ-024 After rst_n release, the block SHALL not detect a start bit until rx_s has been sampled low (no spurious frame from synchronizer flush).

Verification (OVERSAMPLE=16)
REQ-025 A bench SHALL drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop), 16 cycles per bit -> out=8'hA5, done high exactly 1 cycle, err=0, busy low after the stop sample.
REQ-026 A bench SHALL drive in low for 4 cycles, then high -> busy rises then falls, with no done and no err, and out unchanged.
REQ-027 A bench SHALL drive frame 0x3C with the stop bit held low -> err pulses 1 cycle, no done, and out keeps its previous value.
REQ-028 A bench SHALL drive back-to-back frames 0x00 then 0xFF with no idle gap -> two done pulses, with out=8'h00 then out=8'hFF.
REQ-029 A bench SHALL assert rst_n=0 during data bit 4 of frame 0x81, then send frame 0x42 -> out=8'h00 during reset, no done for the aborted frame, then out=8'h42 with a single done.
REQ-030 A bench SHALL hold en=0 while sending frame 0x55 -> busy stays 0, with no done and no err.
